seq_stage_ctrl: RTL
===================

SEQ_STAGE_CTRL -- requirements
Module: seq_stage_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of the retired-instruction counter.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-004 SHALL have port start  input  1  one-cycle pulse, begins execution from IDLE.
REQ-005 SHALL have port icode  input  4  instruction code from fetch logic, valid during FETCH.
REQ-006 SHALL have port imem_error  input  1  fetch address invalid, sampled in FETCH.
REQ-007 SHALL have port dmem_error  input  1  data address invalid, sampled in MEMORY when mem_ready=1.
REQ-008 SHALL have port mem_ready  input  1  data-memory access complete.
REQ-009 SHALL have ports fetch_en, decode_en, execute_en, memory_en, writeback_en, pcupd_en  output  1 each  stage enables, at most one high.
REQ-010 SHALL have port stat  output  2  processor status: 00 AOK, 01 HLT, 10 ADR, 11 INS.
REQ-011 SHALL have ports busy, halted  output  1 each  busy high in any stage state; halted high in HALT.
REQ-012 SHALL have port retired  output  CNT_W  count of instructions completing PCUPD.

Function
REQ-013 SHALL implement states IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPD, HALT.
REQ-014 SHALL drive stage enables as Moore outputs: exactly the enable of the current stage state, all low in IDLE/HALT.
REQ-015 SHALL move IDLE->FETCH on start=1; start ignored in all other states.
REQ-016 SHALL latch icode into icode_q on the FETCH cycle; later states use icode_q only.
REQ-017 SHALL, in FETCH: imem_error=1 -> stat=ADR, HALT; else icode>4'hB -> stat=INS, HALT; else DECODE (imem_error has priority).
REQ-018 SHALL move DECODE->EXECUTE unconditionally, one cycle each.
REQ-019 SHALL move EXECUTE->MEMORY for icode_q in {4,5,8,9,A,B}, else to WRITEBACK if it writes registers, else PCUPD.
REQ-020 SHALL hold MEMORY (memory_en high) while mem_ready=0, with no timeout.
REQ-021 SHALL, in MEMORY with mem_ready=1: dmem_error=1 -> stat=ADR, HALT; else WRITEBACK if icode_q writes registers, else PCUPD.
REQ-022 SHALL treat icode_q in {2,3,5,6,8,9,A,B} as register-writing; {0,1,4,7} skip WRITEBACK.
REQ-023 SHALL move WRITEBACK->PCUPD unconditionally.
REQ-024 SHALL, in PCUPD, increment retired by 1 (wrapping modulo 2^CNT_W); icode_q=0 -> stat=HLT, HALT; else FETCH.
REQ-025 SHALL give latencies: nop/halt 4 cycles, irmovq/OPq 5, rmmovq 5+W, mrmovq/pop/push/call/ret 6+W, where W = MEMORY cycles with mem_ready=0.
REQ-026 SHALL remain in HALT, ignoring start, until rst_n=0; faulting instructions do not increment retired.

Reset
REQ-027 SHALL, when rst_n=0 at a rising edge, enter IDLE from any state, including mid-MEMORY wait, regardless of other inputs.
REQ-028 SHALL reset outputs: all enables 0, stat=AOK, busy=0, halted=0, retired=0, icode_q=0.

Structure
REQ-029 SHALL take state enum, Y86 icode constants (IHALT..IPOPQ) and stat codes from shared package seq_pkg.
REQ-030 SHALL place icode classification (valid, needs_mem, writes_reg) in combinational sub-module icode_class, instantiated once.

Verification
REQ-031 SHALL cover: reset, start, icode=1 then 0 -> enables F,D,E,P twice; stat=HLT; retired=2; halted=1.
REQ-032 SHALL cover: icode=5, mem_ready low 3 cycles -> memory_en high 4 cycles, then writeback_en 1 cycle, retired +1.
REQ-033 SHALL cover: icode=4'hC in FETCH -> next cycle HALT, stat=INS, retired unchanged.
REQ-034 SHALL cover: imem_error=1 with icode=4'hC -> stat=ADR (priority over INS).
REQ-035 SHALL cover: icode=9, dmem_error=1 with mem_ready=1 -> stat=ADR, writeback_en never asserted.
REQ-036 SHALL cover: rst_n=0 during MEMORY wait -> IDLE next edge, all outputs at reset values; start then restarts at FETCH.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared definitions for the sequential Y86 stage controller: states, icodes, status codes.
package seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK, S_PCUPD, S_HALT
  } state_t;

  typedef enum logic [1:0] {
    STAT_AOK = 2'b00,
    STAT_HLT = 2'b01,
    STAT_ADR = 2'b10,
    STAT_INS = 2'b11
  } stat_t;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  typedef struct packed {
    logic valid;
    logic needs_mem;
    logic writes_reg;
  } icls_t;

endpackage

// File: rtl/icode_class.sv
// Combinational icode classifier: legality, data-memory use and register write-back.
module icode_class
  import seq_pkg::*;
(
  input  logic [3:0] icode,
  output icls_t      cls
);

  always_comb begin
    cls = '0;
    cls.valid = (icode <= IPOPQ);
    case (icode)
      IRMMOVQ, IMRMOVQ, ICALL, IRET, IPUSHQ, IPOPQ: cls.needs_mem = 1'b1;
      default: ;
    endcase
    case (icode)
      IRRMOVQ, IIRMOVQ, IMRMOVQ, IOPQ, ICALL, IRET, IPUSHQ, IPOPQ: cls.writes_reg = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/seq_stage_ctrl.sv
// Sequential (non-pipelined) Y86 stage sequencer: one stage enable per cycle, status and retire count.
module seq_stage_ctrl
  import seq_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       icode,
  input  logic             imem_error,
  input  logic             dmem_error,
  input  logic             mem_ready,
  output logic             fetch_en,
  output logic             decode_en,
  output logic             execute_en,
  output logic             memory_en,
  output logic             writeback_en,
  output logic             pcupd_en,
  output logic [1:0]       stat,
  output logic             busy,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  state_t           state, state_nx;
  stat_t            stat_q, stat_nx;
  logic [3:0]       icode_q;
  logic [3:0]       cls_icode;
  icls_t            cls;
  logic [CNT_W-1:0] retired_q;

  // The single classifier sees the live icode while fetching and the latched one afterwards.
  assign cls_icode = (state == S_FETCH) ? icode : icode_q;

  icode_class u_cls (
    .icode (cls_icode),
    .cls   (cls)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      stat_q    <= STAT_AOK;
      icode_q   <= '0;
      retired_q <= '0;
    end else begin
      state  <= state_nx;
      stat_q <= stat_nx;
      if (state == S_FETCH) icode_q <= icode;
      if (state == S_PCUPD) retired_q <= retired_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_nx = state;
    stat_nx  = stat_q;
    case (state)
      S_IDLE:    if (start) state_nx = S_FETCH;
      S_FETCH: begin
        if (imem_error) begin
          stat_nx  = STAT_ADR;
          state_nx = S_HALT;
        end else if (!cls.valid) begin
          stat_nx  = STAT_INS;
          state_nx = S_HALT;
        end else begin
          state_nx = S_DECODE;
        end
      end
      S_DECODE:  state_nx = S_EXECUTE;
      S_EXECUTE: begin
        if (cls.needs_mem)       state_nx = S_MEMORY;
        else if (cls.writes_reg) state_nx = S_WRITEBACK;
        else                     state_nx = S_PCUPD;
      end
      // Unbounded wait on the data memory; dmem_error only counts once the access completes.
      S_MEMORY: begin
        if (mem_ready) begin
          if (dmem_error) begin
            stat_nx  = STAT_ADR;
            state_nx = S_HALT;
          end else if (cls.writes_reg) begin
            state_nx = S_WRITEBACK;
          end else begin
            state_nx = S_PCUPD;
          end
        end
      end
      S_WRITEBACK: state_nx = S_PCUPD;
      S_PCUPD: begin
        if (icode_q == IHALT) begin
          stat_nx  = STAT_HLT;
          state_nx = S_HALT;
        end else begin
          state_nx = S_FETCH;
        end
      end
      S_HALT:  state_nx = S_HALT;
      default: state_nx = S_IDLE;
    endcase
  end

  assign fetch_en     = (state == S_FETCH);
  assign decode_en    = (state == S_DECODE);
  assign execute_en   = (state == S_EXECUTE);
  assign memory_en    = (state == S_MEMORY);
  assign writeback_en = (state == S_WRITEBACK);
  assign pcupd_en     = (state == S_PCUPD);
  assign busy         = fetch_en | decode_en | execute_en | memory_en | writeback_en | pcupd_en;
  assign halted       = (state == S_HALT);
  assign stat         = stat_q;
  assign retired      = retired_q;

endmodule
